// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer
// Sequences a downstream N-tap FIR: on cfg_go it pulses the filter reset,
// streams exactly N coefficients into it, then forwards samples as start
// strobes and flags the cycles in which y_out carries a full result.
//
// Optional feature macro: FIR_SEQ_CSUM_EN (16-bit running sum of the loaded
// coefficients on csum; csum is tied to 0 when undefined).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_go              clear filter and reload coefficients
//   c_valid/c_data/c_ready  coefficient stream (accepted in LOAD)
//   s_valid/s_data/s_ready  sample stream (accepted in RUN)
//   fir_rst             registered reset pulse to the filter
//   load_coeff/coeff_in coefficient write strobe and data
//   start/x_in          sample advance strobe and data
//   y_valid             filter output valid
//   loaded              coefficient set complete (RUN)
//   csum                coefficient checksum
module fir_coeff_sequencer #(
  parameter int N    = 100,
  parameter int FILL = N + 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_go,
  input  logic               c_valid,
  input  logic signed [15:0] c_data,
  output logic               c_ready,
  input  logic               s_valid,
  input  logic signed [15:0] s_data,
  output logic               s_ready,
  output logic               fir_rst,
  output logic               load_coeff,
  output logic signed [15:0] coeff_in,
  output logic               start,
  output logic signed [15:0] x_in,
  output logic               y_valid,
  output logic               loaded,
  output logic        [15:0] csum
);

  localparam int CW = $clog2(N + 1);
  localparam int FW = $clog2(FILL + 1);

  typedef enum logic [1:0] {IDLE, CLR, LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ccnt;
  logic [FW-1:0]   fill_cnt;
  logic            c_acc, s_acc;

  // cfg_go takes priority over any handshake in the same cycle
  assign c_ready = (state_q == LOAD) && !cfg_go;
  assign s_ready = (state_q == RUN)  && !cfg_go;
  assign c_acc   = c_valid && c_ready;
  assign s_acc   = s_valid && s_ready;
  assign loaded  = (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_go) state_d = CLR;
      CLR:     state_d = LOAD;
      LOAD:    if (cfg_go)                                   state_d = CLR;
               else if (c_acc && ccnt == CW'(N - 1))         state_d = RUN;
      RUN:     if (cfg_go) state_d = CLR;
      default: state_d = IDLE;
    endcase
  end

  // Coefficient counter; a restart in LOAD drops the partial set at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            ccnt <= '0;
    else if (state_q == CLR || (state_q == LOAD && cfg_go)) ccnt <= '0;
    else if (c_acc)                                     ccnt <= ccnt + 1'b1;
  end

  // Start pulses since the last clear, saturating at FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      fill_cnt <= '0;
    else if (state_q == CLR)                      fill_cnt <= '0;
    else if (start && fill_cnt != FW'(FILL))      fill_cnt <= fill_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_rst    <= 1'b1;
      load_coeff <= 1'b0;
      coeff_in   <= '0;
      start      <= 1'b0;
      x_in       <= '0;
      y_valid    <= 1'b0;
    end else begin
      fir_rst    <= (state_q == CLR);
      load_coeff <= c_acc;
      if (c_acc) coeff_in <= c_data;
      start      <= s_acc;
      if (s_acc) x_in <= s_data;
      // fill_cnt holds prior starts, so this start's ordinal is fill_cnt+1.
      // Gating on the next state keeps y_valid out of CLR after a late cfg_go.
      y_valid    <= start && (fill_cnt >= FW'(FILL - 1)) && (state_d == RUN);
    end
  end

`ifdef FIR_SEQ_CSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 csum_q <= '0;
    else if (state_q == CLR) csum_q <= '0;
    else if (c_acc)          csum_q <= csum_q + $unsigned(c_data);
  end
  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Self-checking bench for fir_coeff_sequencer (N=4, FILL=7): directed
// scenarios followed by random traffic, each cycle compared against a
// transaction-level reference model.
module tb_fir_coeff_sequencer;
  localparam int N = 4, FILL = 7;

  logic clk = 0, rst = 0, cfg_go = 0, c_valid = 0, s_valid = 0;
  logic [15:0] c_data = 0, s_data = 0;
  logic c_ready, s_ready, fir_rst, load_coeff, start, y_valid, loaded;
  logic [15:0] coeff_in, x_in, csum;

  int vectors = 0, miscompares = 0;
  int n_load, n_start, n_yv, n_frst;

  always #5 clk = ~clk;

  fir_coeff_sequencer #(.N(N), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_rst(fir_rst), .load_coeff(load_coeff), .coeff_in(coeff_in),
    .start(start), .x_in(x_in), .y_valid(y_valid),
    .loaded(loaded), .csum(csum)
  );

  // Reference model: loads done since the last clear (-1 = never configured),
  // a pending clear cycle, starts since clear, and the expected outputs.
  int          m_loads, m_starts;
  bit          m_clr, m_acc_c;
  logic [15:0] m_csum;
  logic        e_fir_rst, e_load, e_start, e_yv;
  logic [15:0] e_coeff, e_x;

  function automatic bit m_running();
    return !m_clr && m_loads == N;
  endfunction
  function automatic bit m_loading();
    return !m_clr && m_loads >= 0 && m_loads < N;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loads = -1; m_starts = 0; m_clr = 0; m_acc_c = 0; m_csum = 0;
    e_fir_rst = 1; e_load = 0; e_start = 0; e_yv = 0; e_coeff = 0; e_x = 0;
  endtask

  task automatic model_step();
    bit run, ldg, acc_c, acc_s, yv;
    run   = m_running();
    ldg   = m_loading();
    acc_c = ldg && c_valid && !cfg_go;
    acc_s = run && s_valid && !cfg_go;
    yv    = e_start && (m_starts + 1 >= FILL) && run && !cfg_go;
    if (e_start && m_starts < FILL) m_starts++;
    e_fir_rst = m_clr;
    e_load    = acc_c;
    if (acc_c) e_coeff = c_data;
    e_start   = acc_s;
    if (acc_s) e_x = s_data;
    e_yv      = yv;
    m_acc_c   = acc_c;
    if (m_clr) begin
      m_clr = 0; m_loads = 0; m_starts = 0; m_csum = 0;
    end else if (cfg_go) begin
      m_clr = 1; m_loads = -1;
    end else if (acc_c) begin
      m_loads++; m_csum += c_data;
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_csum;
`ifdef FIR_SEQ_CSUM_EN
    exp_csum = m_csum;
`else
    exp_csum = 16'h0;
`endif
    check1("c_ready", c_ready, m_loading() && !cfg_go);
    check1("s_ready", s_ready, m_running() && !cfg_go);
    check1("fir_rst", fir_rst, e_fir_rst);
    check1("load_coeff", load_coeff, e_load);
    check16("coeff_in", coeff_in, e_coeff);
    check1("start", start, e_start);
    check16("x_in", x_in, e_x);
    check1("y_valid", y_valid, e_yv);
    check1("loaded", loaded, m_running());
    check16("csum", csum, exp_csum);
    n_load  += int'(load_coeff);
    n_start += int'(start);
    n_yv    += int'(y_valid);
    n_frst  += int'(fir_rst);
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cyc(input logic g, input logic cv, input logic [15:0] cd,
                     input logic sv, input logic [15:0] sd);
    cfg_go = g; c_valid = cv; c_data = cd; s_valid = sv; s_data = sd;
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic do_reset();
    cfg_go = 0; c_valid = 0; s_valid = 0;
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Present a coefficient set until the model reports the set complete.
  task automatic load_set(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3,
                          input bit toggle);
    logic [15:0] cs[4];
    int k;
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    k = 0;
    for (int i = 0; i < 40 && !m_running(); i++) begin
      cyc(0, toggle ? logic'(i % 2 == 0) : 1'b1, cs[k], 0, 16'h0);
      if (m_acc_c && k < 3) k++;
    end
    check1("load_done", loaded, 1'b1);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 1, 16'($urandom));
  endtask

  initial begin
    #2;
    do_reset();

    // Load 1,2,3,4 with c_valid held high
    cyc(1, 0, 16'h0, 0, 16'h0);
    n_load = 0; n_frst = 0;
    load_set(16'd1, 16'd2, 16'd3, 16'd4, 0);
    idle(2);
    check16("loads_held", 16'(n_load), 16'd4);
    check16("frst_pulses", 16'(n_frst), 16'd1);
    check16("coeff_last", coeff_in, 16'd4);

    // Ten back-to-back samples: y_valid after starts 7..10
    n_start = 0; n_yv = 0;
    samples(10);
    idle(3);
    check16("starts_10", 16'(n_start), 16'd10);
    check16("yvalid_4", 16'(n_yv), 16'd4);

    // Reload with c_valid toggling
    cyc(1, 0, 16'h0, 0, 16'h0);
    n_load = 0;
    load_set(16'd5, 16'd6, 16'd7, 16'd8, 1);
    idle(2);
    check16("loads_toggle", 16'(n_load), 16'd4);

    // Restart after two accepted coefficients
    cyc(1, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'd11, 0, 16'h0);
    cyc(0, 1, 16'd11, 0, 16'h0);
    cyc(0, 1, 16'd12, 0, 16'h0);
    cyc(1, 1, 16'd13, 0, 16'h0);
    n_load = 0;
    load_set(16'd21, 16'd22, 16'd23, 16'd24, 0);
    idle(2);
    check16("loads_restart", 16'(n_load), 16'd4);
    check16("coeff_restart", coeff_in, 16'd24);

    // cfg_go with s_valid in RUN: no start, fill restarts
    samples(3);
    cyc(1, 0, 16'h0, 1, 16'h1234);
    n_frst = 0;
    load_set(16'd1, 16'd2, 16'd3, 16'd4, 0);
    check16("frst_run", 16'(n_frst), 16'd1);
    n_start = 0; n_yv = 0;
    samples(10);
    idle(3);
    check16("starts_refill", 16'(n_start), 16'd10);
    check16("yvalid_refill", 16'(n_yv), 16'd4);

    // Checksum wraps modulo 2^16
    cyc(1, 0, 16'h0, 0, 16'h0);
    load_set(16'h8000, 16'h8000, 16'h0005, 16'h0007, 0);
    idle(1);
`ifdef FIR_SEQ_CSUM_EN
    check16("csum_wrap", csum, 16'h000C);
`else
    check16("csum_off", csum, 16'h0000);
`endif

    // Reset in the middle of LOAD: no further strobes
    cyc(1, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'd9, 0, 16'h0);
    cyc(0, 1, 16'd9, 0, 16'h0);
    do_reset();
    n_load = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'd77, 1, 16'd66);
    check16("loads_after_rst", 16'(n_load), 16'd0);

    // Random traffic with an occasional restart and one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cyc(logic'($urandom_range(0, 24) == 0), logic'($urandom_range(0, 9) < 7),
          16'($urandom), logic'($urandom_range(0, 9) < 6), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
